// File: rtl/dm_access_unit.sv
// dm_access_unit: initiator side of the word-wide data-memory port.
// Converts byte/half/word load/store requests into DM read and write cycles.
// Sub-word stores are done as a read-modify-write because DM only writes whole words.
module dm_access_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] dm_addr2,
    output logic [31:0]       dm_din,
    output logic              dm_memwr,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [31:0]       din_q;
    logic [31:0]       rdata_q;

    logic              req_misalign;
    logic [15:0]       lane_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // Byte-address bits above the DM word address wrap around.
    logic              unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    // Alignment check on the incoming request (size 11 behaves as word).
    always_comb begin
        req_misalign = 1'b0;
        if (size == 2'b01) begin
            req_misalign = addr[0];
        end else if (size[1]) begin
            req_misalign = (addr[1:0] != 2'b00);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (req_misalign) begin
                        state_d = StErr;
                    end else if (!we) begin
                        state_d = StRd;
                    end else if (size[1]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StDone;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load lane extraction and store lane merge on the word read from DM.
    always_comb begin
        lane_half = 16'(dm_dout >> {lane_q, 3'b000});
        load_val  = dm_dout;
        case (size_q)
            2'b00: load_val = sign_q ? {{24{lane_half[7]}}, lane_half[7:0]}
                                     : {24'h0, lane_half[7:0]};
            2'b01: load_val = sign_q ? {{16{lane_half[15]}}, lane_half}
                                     : {16'h0, lane_half};
            default: load_val = dm_dout;
        endcase
        merged = dm_dout;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Request capture and datapath registers; DM address/data hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            addr2_q <= '0;
            din_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sign_q  <= sign_ext;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata;
                        if (!req_misalign) begin
                            addr2_q <= addr[ADDR_W+1:2];
                            // Word stores skip the read, so the write data is ready now.
                            if (we && size[1]) begin
                                din_q <= wdata;
                            end
                        end
                    end
                end
                StRd: begin
                    if (we_q) begin
                        din_q <= merged;
                    end else begin
                        rdata_q <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only, so dm_memwr cannot glitch.
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone) || (state_q == StErr);
        misalign = (state_q == StErr);
        dm_memwr = (state_q == StWr);
        dm_addr2 = addr2_q;
        dm_din   = din_q;
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Testbench for dm_access_unit: DM environment, transaction-level reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_dm_access_unit;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       wdata = 32'h0;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic [ADDR_W-1:0] dm_addr2;
    logic [31:0]       dm_din;
    logic              dm_memwr;
    logic [31:0]       dm_dout;

    int n_checks = 0;
    int n_errors = 0;

    dm_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .dm_addr2 (dm_addr2),
        .dm_din   (dm_din),
        .dm_memwr (dm_memwr),
        .dm_dout  (dm_dout)
    );

    always #5 clk = ~clk;

    // Power-on contents of DM, a fixed hash of the word index.
    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- DM environment: combinational read, word write on posedge ----------------
    logic [31:0] dm_mem   [1024];
    bit          dm_wrote [1024];

    function automatic logic [31:0] env_word(input logic [9:0] i);
        return dm_wrote[i] ? dm_mem[i] : init_word(int'(i));
    endfunction

    assign dm_dout = env_word(dm_addr2);

    always @(posedge clk) begin
        if (dm_memwr) begin
            dm_mem[dm_addr2]   <= dm_din;
            dm_wrote[dm_addr2] <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem   [1024];
    bit          ref_wrote [1024];

    function automatic logic [31:0] ref_word(input logic [9:0] i);
        return ref_wrote[i] ? ref_mem[i] : init_word(int'(i));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] lane);
        logic [31:0] v;
        v = w >> (8 * lane);
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] mask;
        if (sz[1]) return wd;
        mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * lane);
        return (old & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return a[0];
        if (sz[1]) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Model state: m_phase counts cycles since acceptance (0 = idle); done falls on m_len,
    // the DM write (if any) on m_wrc.
    int          m_phase = 0;
    int          m_len   = 0;
    int          m_wrc   = 0;
    bit          m_err   = 1'b0;
    bit          m_load  = 1'b0;
    logic [9:0]  m_idx   = '0;
    logic [31:0] m_wval  = 32'h0;
    logic [31:0] m_ldval = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    // Transaction-level model advanced on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_rdata <= 32'h0;
        end else if (m_phase == 0) begin
            if (req) begin
                m_phase <= 1;
                m_idx   <= addr[11:2];
                m_err   <= ref_misaligned(size, addr);
                m_load  <= !we;
                m_ldval <= ref_load(ref_word(addr[11:2]), size, sign_ext, addr[1:0]);
                m_wval  <= ref_merge(ref_word(addr[11:2]), wdata, size, addr[1:0]);
                if (ref_misaligned(size, addr)) begin
                    m_len <= 1; m_wrc <= 0;
                end else if (!we) begin
                    m_len <= 2; m_wrc <= 0;
                end else if (size[1]) begin
                    m_len <= 2; m_wrc <= 1;
                end else begin
                    m_len <= 3; m_wrc <= 2;
                end
            end
        end else begin
            if (m_phase == m_wrc) begin
                ref_mem[m_idx]   <= m_wval;
                ref_wrote[m_idx] <= 1'b1;
            end
            if (m_load && !m_err && (m_phase + 1 == m_len)) m_rdata <= m_ldval;
            m_phase <= (m_phase == m_len) ? 0 : m_phase + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase != 0 && m_phase == m_len));
            chk("misalign", 32'(misalign), 32'(m_phase != 0 && m_phase == m_len && m_err));
            chk("dm_memwr", 32'(dm_memwr), 32'(m_phase != 0 && m_phase == m_wrc));
            chk("rdata", rdata, m_rdata);
            if (m_phase != 0 && !m_err) chk("dm_addr2", 32'(dm_addr2), 32'(m_idx));
            if (m_phase != 0 && m_phase == m_wrc) chk("dm_din", dm_din, m_wval);
        end
    end

    // Issue one request starting at posedge+1 of an idle cycle; returns cycles to done.
    // With hold, req stays high and the other inputs are scrambled while busy.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input bit hold,
                         output int lat);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            if (hold) begin
                we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
                addr = $urandom; wdata = $urandom;
            end
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_within_bound", 32'(lat != 0), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [31:0] ra;

    initial begin
        // Reset state, checked while reset is held and no clock edge has occurred.
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_memwr", 32'(dm_memwr), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        chk("rst_dm_addr2", 32'(dm_addr2), 32'h0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load.
        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lat);
        chk("sw_latency", 32'(lat), 32'd2);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk("lw_latency", 32'(lat), 32'd2);
        chk("lw_rdata", rdata, 32'hDEADBEEF);

        // Byte read-modify-write.
        do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, lat);
        do_op(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, lat);
        chk("sb_latency", 32'(lat), 32'd3);
        chk("sb_word", env_word(10'd8), 32'h1122AA44);
        chk("sb_below", env_word(10'd7), init_word(7));
        chk("sb_above", env_word(10'd9), init_word(9));
        do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, lat);
        chk("sb_readback", rdata, 32'h1122AA44);

        // Sign and zero extension.
        do_op(1'b1, 2'b10, 1'b0, 32'h30, 32'h000080F0, 1'b0, lat);
        do_op(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0, lat);
        chk("lb", rdata, 32'hFFFFFFF0);
        do_op(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 1'b0, lat);
        chk("lbu", rdata, 32'h000000F0);
        do_op(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0, lat);
        chk("lh", rdata, 32'hFFFF80F0);

        // Misaligned word load.
        do_op(1'b0, 2'b10, 1'b0, 32'h32, 32'h0, 1'b0, lat);
        chk("misalign_latency", 32'(lat), 32'd1);
        chk("misalign_rdata_kept", rdata, 32'hFFFF80F0);

        // Reset asserted during the write cycle of a word store.
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h40; wdata = 32'h12345678;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("wr_cycle_memwr", 32'(dm_memwr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_memwr", 32'(dm_memwr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_misalign", 32'(misalign), 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_dm_din", dm_din, 32'h0);
        chk("midrst_dm_addr2", 32'(dm_addr2), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_word_kept", env_word(10'd16), init_word(16));

        // Back-to-back with req held high; 0x1004 aliases word 1.
        do_op(1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFEF00D, 1'b1, lat);
        chk("alias_sw_latency", 32'(lat), 32'd2);
        do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1, lat);
        chk("alias_lw_latency", 32'(lat), 32'd2);
        chk("alias_rdata", rdata, 32'hCAFEF00D);
        chk("alias_word1", env_word(10'd1), 32'hCAFEF00D);
        do_op(1'b0, 2'b01, 1'b1, 32'h1006, 32'h0, 1'b1, lat);
        chk("alias_lh_hi", rdata, 32'hFFFFCAFE);
        req = 1'b0;

        // Randomized traffic over a small window of words so RMW and loads collide.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            ra[11:2] = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) ra[31:12] = 20'h0;
            do_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                  1'($urandom), lat);
            req = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (2) begin
            @(posedge clk); #1;
        end

        // DM contents must match the model everywhere.
        for (int i = 0; i < 1024; i++) begin
            chk("mem_sweep", env_word(10'(i)), ref_word(10'(i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
